mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter for the shared picorv32-style memory/MMIO bus.
// Owner's request is latched onto bus_*, held until bus_ready, then a one-cycle
// mX_ready pulse returns the captured read data. Ties go to the master that did
// not complete the previous transaction (round-robin).
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   m0_valid/addr/wdata/wstrb    CPU request (wstrb 0 = read)
//   m0_ready/rdata               CPU completion pulse and read data
//   m1_*                         same as m0_*, secondary master (DMA / debug loader)
//   bus_valid/addr/wdata/wstrb   latched request to the address decode/mux
//   bus_ready/rdata              slave completion and read data
//   grant                        current/last owner (0 = m0, 1 = m1)
//   timeout_err                  one-cycle pulse on watchdog forced completion
//
// Optional feature: define BUS_TIMEOUT_EN to enable the BUSY watchdog
// (TIMEOUT_CYCLES). Without it BUSY waits indefinitely and timeout_err stays 0.

module mem_bus_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        grant,
    output logic        timeout_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned TMR_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                bus_valid_q, bus_valid_d;
    logic [DATA_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
    logic                m0_ready_q, m0_ready_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic                m1_ready_q, m1_ready_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                timeout_err_q, timeout_err_d;

    // Completion request from the BUSY state, applied to the owner's response regs
    logic                finish_c;
    logic [DATA_W-1:0]   finish_data_c;
    logic                pick_m1_c;

`ifdef BUS_TIMEOUT_EN
    logic [TMR_W-1:0]    timer_q, timer_d;
`else
    logic                unused_timeout_c;
    assign unused_timeout_c = ^TIMEOUT_CYCLES;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        bus_valid_d   = bus_valid_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_wstrb_d   = bus_wstrb_q;
        m0_ready_d    = 1'b0;
        m0_rdata_d    = m0_rdata_q;
        m1_ready_d    = 1'b0;
        m1_rdata_d    = m1_rdata_q;
        timeout_err_d = 1'b0;
        finish_c      = 1'b0;
        finish_data_c = '0;
        // m1 wins only when alone, or on a tie when m0 completed last
        pick_m1_c     = m1_valid && (!m0_valid || !last_grant_q);
`ifdef BUS_TIMEOUT_EN
        timer_d       = timer_q;
`endif

        case (state_q)
            S_IDLE: begin
                bus_valid_d = 1'b0;
                if (m0_valid || m1_valid) begin
                    grant_d     = pick_m1_c;
                    bus_addr_d  = pick_m1_c ? m1_addr  : m0_addr;
                    bus_wdata_d = pick_m1_c ? m1_wdata : m0_wdata;
                    bus_wstrb_d = pick_m1_c ? m1_wstrb : m0_wstrb;
                    bus_valid_d = 1'b1;
                    state_d     = S_BUSY;
`ifdef BUS_TIMEOUT_EN
                    timer_d     = '0;
`endif
                end
            end
            S_BUSY: begin
                // Slave completion takes priority over watchdog expiry
                if (bus_ready) begin
                    finish_c      = 1'b1;
                    finish_data_c = bus_rdata;
                end
`ifdef BUS_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 16'd1)) begin
                    finish_c      = 1'b1;
                    finish_data_c = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    timer_d = TMR_W'(timer_q + 16'd1);
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                bus_valid_d = 1'b0;
            end
        endcase

        if (finish_c) begin
            if (grant_q) begin
                m1_ready_d = 1'b1;
                m1_rdata_d = finish_data_c;
            end else begin
                m0_ready_d = 1'b1;
                m0_rdata_d = finish_data_c;
            end
            bus_valid_d  = 1'b0;
            last_grant_d = grant_q;
            state_d      = S_DONE;
        end
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            bus_valid_q   <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_wstrb_q   <= '0;
            m0_ready_q    <= 1'b0;
            m0_rdata_q    <= '0;
            m1_ready_q    <= 1'b0;
            m1_rdata_q    <= '0;
            timeout_err_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            timer_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            bus_valid_q   <= bus_valid_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_wstrb_q   <= bus_wstrb_d;
            m0_ready_q    <= m0_ready_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_ready_q    <= m1_ready_d;
            m1_rdata_q    <= m1_rdata_d;
            timeout_err_q <= timeout_err_d;
`ifdef BUS_TIMEOUT_EN
            timer_q       <= timer_d;
`endif
        end
    end

    assign bus_valid   = bus_valid_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_wstrb   = bus_wstrb_q;
    assign m0_ready    = m0_ready_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_ready    = m1_ready_q;
    assign m1_rdata    = m1_rdata_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter.
// Inputs are driven 1 time unit after posedge; outputs are sampled at the same
// point, so each tick() advances exactly one clock cycle.

module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_valid;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        grant;
    logic        timeout_err;

    int tests_run;
    int tests_failed;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        bus_ready = 1'b0; bus_rdata = '0;
        tick(); tick();
        tests_run++;
        if ({bus_valid, bus_addr, bus_wdata, bus_wstrb, m0_ready, m0_rdata,
             m1_ready, m1_rdata, grant, timeout_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%0b addr=%h wd=%h ws=%h r0=%0b rd0=%h r1=%0b rd1=%h g=%0b te=%0b, want all 0",
                     bus_valid, bus_addr, bus_wdata, bus_wstrb, m0_ready, m0_rdata,
                     m1_ready, m1_rdata, grant, timeout_err);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        m0_valid = 1'b1; m0_addr = 32'h4000_0010; m0_wstrb = 4'h0; m0_wdata = 32'h0;
        tick();                                   // N+1
        m0_valid = 1'b0;
        tests_run++;
        if (bus_valid !== 1'b1 || bus_addr !== 32'h4000_0010 || grant !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_bus_req: got valid=%0b addr=%h grant=%0b, want 1 40000010 0",
                     bus_valid, bus_addr, grant);
        end
        tests_run++;
        if (m0_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_ready_early: got %0b want 0", m0_ready);
        end
        bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();                                   // N+2
        bus_ready = 1'b0;
        tests_run++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m1_ready !== 1'b0 || bus_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_complete: got r0=%0b rd0=%h r1=%0b valid=%0b, want 1 deadbeef 0 0",
                     m0_ready, m0_rdata, m1_ready, bus_valid);
        end
        tick();                                   // N+3, back in IDLE
        tests_run++;
        if (m0_ready !== 1'b0 || bus_valid !== 1'b0 || m1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_pulse_width: got r0=%0b valid=%0b r1=%0b, want 0 0 0",
                     m0_ready, bus_valid, m1_ready);
        end
    endtask

    task automatic test_round_robin();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        bus_ready = 1'b1; bus_rdata = 32'h1111_0000;
        m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
        m0_wstrb = 4'h0; m1_wstrb = 4'h0;
        for (int round = 0; round < 2; round++) begin
            m0_valid = 1'b1; m1_valid = 1'b1;
            tick();                               // BUSY for m0
            tests_run++;
            if (grant !== 1'b0 || bus_addr !== 32'h0000_0100) begin
                tests_failed++;
                $display("FAIL rr_first_m0 round%0d: got grant=%0b addr=%h, want 0 00000100",
                         round, grant, bus_addr);
            end
            tick();                               // DONE for m0
            m0_valid = 1'b0;
            tests_run++;
            if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_m0_ready round%0d: got r0=%0b r1=%0b, want 1 0", round, m0_ready, m1_ready);
            end
            tick();                               // IDLE, gap cycle
            tests_run++;
            if (bus_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_idle_gap round%0d: got valid=%0b want 0", round, bus_valid);
            end
            tick();                               // BUSY for m1
            tests_run++;
            if (grant !== 1'b1 || bus_addr !== 32'h0000_0200) begin
                tests_failed++;
                $display("FAIL rr_second_m1 round%0d: got grant=%0b addr=%h, want 1 00000200",
                         round, grant, bus_addr);
            end
            tick();                               // DONE for m1
            m1_valid = 1'b0;
            tests_run++;
            if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_m1_ready round%0d: got r1=%0b r0=%0b, want 1 0", round, m1_ready, m0_ready);
            end
            tick();                               // IDLE
        end
        bus_ready = 1'b0;
    endtask

    task automatic test_write_wait();
        m1_valid = 1'b1; m1_addr = 32'hC300_0004; m1_wdata = 32'h0000_00A5; m1_wstrb = 4'hF;
        bus_rdata = 32'h5555_AAAA;
        tick();                                   // N+1, first BUSY cycle
        for (int k = 1; k <= 4; k++) begin
            tests_run++;
            if (bus_valid !== 1'b1 || bus_addr !== 32'hC300_0004 || bus_wdata !== 32'h0000_00A5 ||
                bus_wstrb !== 4'hF || grant !== 1'b1 || m1_ready !== 1'b0 || timeout_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL write_busy_stable k=%0d: got v=%0b a=%h wd=%h ws=%h g=%0b r1=%0b te=%0b",
                         k, bus_valid, bus_addr, bus_wdata, bus_wstrb, grant, m1_ready, timeout_err);
            end
            m1_valid = 1'b0;                      // owner drop mid-BUSY is ignored
            if (k == 4) bus_ready = 1'b1;
            tick();
        end
        bus_ready = 1'b0;                         // now N+5
        tests_run++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'h5555_AAAA || bus_valid !== 1'b0 || m0_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_complete: got r1=%0b rd1=%h v=%0b r0=%0b, want 1 5555aaaa 0 0",
                     m1_ready, m1_rdata, bus_valid, m0_ready);
        end
        tests_run++;
        if (m0_rdata !== 32'h1111_0000) begin
            tests_failed++;
            $display("FAIL write_nonowner_rdata: got %h want 11110000", m0_rdata);
        end
        tick();
        tests_run++;
        if (m1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_pulse_width: got %0b want 0", m1_ready);
        end
    endtask

    task automatic test_no_starvation();
        int txn;
        int m1_txn;
        logic prev_valid;
        txn = 0; m1_txn = 0; prev_valid = 1'b0;
        bus_ready = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h0000_0300; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h0000_0400; m1_wstrb = 4'h0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus_valid && !prev_valid) begin
                txn++;
                if (grant && m1_txn == 0) m1_txn = txn;
            end
            prev_valid = bus_valid;
            if (m1_ready) m1_valid = 1'b0;
        end
        tests_run++;
        if (m1_txn < 1 || m1_txn > 2) begin
            tests_failed++;
            $display("FAIL no_starvation: m1 granted at txn %0d of %0d, want 1..2", m1_txn, txn);
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick(); tick(); tick();
        bus_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        // m0 completes first so last owner is m0; reset must restore m0 tie priority
        bus_ready = 1'b1; bus_rdata = 32'hCAFE_0001;
        m0_valid = 1'b1; m0_addr = 32'h0000_0500;
        tick(); m0_valid = 1'b0;
        tick(); tick();
        bus_ready = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0600;
        tick();                                   // BUSY
        m0_valid = 1'b0;
        tests_run++;
        if (bus_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_busy_pre: got valid=%0b want 1", bus_valid);
        end
        reset_n = 1'b0;
        tick();
        tests_run++;
        if (bus_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || m0_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_busy_abandon: got v=%0b r0=%0b r1=%0b rd0=%h, want 0 0 0 0",
                     bus_valid, m0_ready, m1_ready, m0_rdata);
        end
        reset_n = 1'b1;
        m0_valid = 1'b1; m1_valid = 1'b1;
        tick();
        tests_run++;
        if (grant !== 1'b0 || bus_valid !== 1'b1 || bus_addr !== 32'h0000_0600) begin
            tests_failed++;
            $display("FAIL rst_first_tie: got grant=%0b v=%0b addr=%h, want 0 1 00000600",
                     grant, bus_valid, bus_addr);
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        bus_ready = 1'b1;
        tick(); tick();
        bus_ready = 1'b0;
        tick();
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        bus_ready = 1'b0; bus_rdata = 32'hFFFF_FFFF;
        m0_valid = 1'b1; m0_addr = 32'h0000_0700;
        tick();                                   // first BUSY cycle
        m0_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tests_run++;
            if (bus_valid !== 1'b1 || m0_ready !== 1'b0 || timeout_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_wait i=%0d: got v=%0b r0=%0b te=%0b, want 1 0 0",
                         i, bus_valid, m0_ready, timeout_err);
            end
            tick();
        end
        tests_run++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'h0 || timeout_err !== 1'b1 || bus_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_fire: got r0=%0b rd0=%h te=%0b v=%0b, want 1 0 1 0",
                     m0_ready, m0_rdata, timeout_err, bus_valid);
        end
        tick();
        tests_run++;
        if (m0_ready !== 1'b0 || timeout_err !== 1'b0 || bus_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_after: got r0=%0b te=%0b v=%0b, want 0 0 0", m0_ready, timeout_err, bus_valid);
        end
    endtask
`endif

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_read();
        test_round_robin();
        test_write_wait();
        test_no_starvation();
        test_reset_mid_busy();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
